// File: rtl/vec_search_engine.sv
// Register-table search engine: scans DEPTH entries one per cycle against a latched key,
// reporting the first match (mode 0) or the total match count (mode 1).
module vec_search_engine #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8,
   localparam int IDXW = $clog2(DEPTH),
   localparam int CNTW = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [IDXW-1:0]  wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             start,
   input  logic [WIDTH-1:0] key,
   input  logic             mode,
   output logic             busy,
   output logic             done,
   output logic             found,
   output logic [IDXW-1:0]  index,
   output logic [CNTW-1:0]  count,
   output logic [WIDTH-1:0] io_out
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t           state_q, state_d;
   logic [IDXW-1:0]  ptr_q, ptr_d;
   logic [WIDTH-1:0] key_q, key_d;
   logic             mode_q, mode_d;
   logic             found_q, found_d;
   logic [IDXW-1:0]  index_q, index_d;
   logic [CNTW-1:0]  count_q, count_d;
   logic [WIDTH-1:0] tbl_q [DEPTH];

   logic             wr_ok;
   logic             match;

   // A write issued alongside an accepted start lands at the same edge, so the scan sees it.
   assign wr_ok = wr_en && (state_q != SCAN) &&
                  ({1'b0, wr_addr} < (IDXW + 1)'(DEPTH));
   assign match = (tbl_q[ptr_q] == key_q);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
      end else if (wr_ok) begin
         tbl_q[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         key_q   <= '0;
         mode_q  <= 1'b0;
         found_q <= 1'b0;
         index_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         key_q   <= key_d;
         mode_q  <= mode_d;
         found_q <= found_d;
         index_q <= index_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      key_d   = key_q;
      mode_d  = mode_q;
      found_d = found_q;
      index_d = index_q;
      count_d = count_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = SCAN;
               key_d   = key;
               mode_d  = mode;
               ptr_d   = '0;
               found_d = 1'b0;
               index_d = '0;
               count_d = '0;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         SCAN: begin
            if (match) begin
               if (count_q != CNTW'(DEPTH)) count_d = count_q + CNTW'(1);
               if (!found_q) begin
                  found_d = 1'b1;
                  index_d = ptr_q;
               end
            end
            if ((match && !mode_q) || (ptr_q == IDXW'(DEPTH - 1))) begin
               state_d = DONE;
            end else begin
               ptr_d = ptr_q + IDXW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy   = (state_q == SCAN);
   assign done   = (state_q == DONE);
   assign found  = found_q;
   assign index  = index_q;
   assign count  = count_q;
   assign io_out = busy ? tbl_q[ptr_q] : '0;

endmodule

// File: tb/tb_vec_search_engine.sv
// Directed bench for vec_search_engine (WIDTH=4, DEPTH=8) with immediate-assertion checks.
module tb_vec_search_engine;

   localparam int WIDTH = 4;
   localparam int DEPTH = 8;
   localparam int IDXW  = 3;
   localparam int CNTW  = 4;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             wr_en = 1'b0;
   logic [IDXW-1:0]  wr_addr = '0;
   logic [WIDTH-1:0] wr_data = '0;
   logic             start = 1'b0;
   logic [WIDTH-1:0] key = '0;
   logic             mode = 1'b0;
   logic             busy, done, found;
   logic [IDXW-1:0]  index;
   logic [CNTW-1:0]  count;
   logic [WIDTH-1:0] io_out;

   int n_checks = 0;
   int n_fail   = 0;

   vec_search_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .key(key), .mode(mode),
      .busy(busy), .done(done), .found(found),
      .index(index), .count(count), .io_out(io_out)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [IDXW-1:0] a, input logic [WIDTH-1:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick;
      wr_en = 1'b0;
   endtask

   // lat counts cycles from the start edge to the done cycle; seq packs io_out nibbles seen while busy.
   task automatic search(input logic [WIDTH-1:0] k, input logic m,
                         input logic do_wr, input logic [IDXW-1:0] wa, input logic [WIDTH-1:0] wd,
                         input logic inject,
                         output int lat, output logic [31:0] seq, output logic first_busy);
      start = 1'b1; key = k; mode = m;
      wr_en = do_wr; wr_addr = wa; wr_data = wd;
      tick;
      start = 1'b0; wr_en = 1'b0;
      lat = 1; seq = '0; first_busy = busy;
      while (!done && lat < 40) begin
         if (busy) seq = {seq[27:0], io_out};
         if (inject && lat == 1) begin
            wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'd7;
            start = 1'b1; key = 4'd5; mode = 1'b1;
         end
         tick;
         start = 1'b0; wr_en = 1'b0;
         lat++;
      end
   endtask

   int          lat;
   logic [31:0] seq;
   logic        fb;

   initial begin
      // Reset state
      #3;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_found", found, 0);
      check("rst_index", index, 0);
      check("rst_count", count, 0);
      check("rst_io_out", io_out, 0);
      tick; tick;
      reset = 1'b1;
      tick;

      wr(3'd0, 4'd3); wr(3'd1, 4'd7); wr(3'd2, 4'd5); wr(3'd3, 4'd7);
      wr(3'd4, 4'd0); wr(3'd5, 4'd9); wr(3'd6, 4'd7); wr(3'd7, 4'd2);

      // First-match, key 7
      search(4'd7, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, lat, seq, fb);
      check("fm_lat", lat, 3);
      check("fm_found", found, 1);
      check("fm_index", index, 1);
      check("fm_count", count, 1);
      check("fm_seq", seq, 32'h37);
      check("fm_busy_in_done", busy, 0);
      tick;
      check("fm_done_pulse", done, 0);
      check("fm_hold_found", found, 1);
      check("fm_hold_index", index, 1);
      check("fm_hold_count", count, 1);

      // Count-all, key 7
      search(4'd7, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0, lat, seq, fb);
      check("ca_lat", lat, 9);
      check("ca_found", found, 1);
      check("ca_index", index, 1);
      check("ca_count", count, 3);
      check("ca_seq", seq, 32'h37570972);
      tick;

      // No match
      search(4'd4, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, lat, seq, fb);
      check("nm_lat", lat, 9);
      check("nm_found", found, 0);
      check("nm_index", index, 0);
      check("nm_count", count, 0);
      tick;

      // Mid-scan write and start are ignored
      search(4'd7, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1, lat, seq, fb);
      check("ms_lat", lat, 3);
      check("ms_found", found, 1);
      check("ms_index", index, 1);
      check("ms_count", count, 1);
      check("ms_seq", seq, 32'h37);
      tick;
      tick;
      search(4'd5, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0, lat, seq, fb);
      check("ms_wr_dropped_count", count, 1);
      check("ms_wr_dropped_index", index, 2);
      tick;

      // Write and start in the same cycle: scan sees the new entry 0
      search(4'd7, 1'b0, 1'b1, 3'd0, 4'd7, 1'b0, lat, seq, fb);
      check("ws_lat", lat, 2);
      check("ws_index", index, 0);
      check("ws_found", found, 1);
      check("ws_count", count, 1);
      check("ws_seq", seq, 32'h7);
      tick;

      // All 15: count saturates at DEPTH, back-to-back start from DONE
      for (int i = 0; i < DEPTH; i++) wr(3'(i), 4'hF);
      search(4'hF, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0, lat, seq, fb);
      check("full_lat", lat, 9);
      check("full_count", count, 8);
      check("full_index", index, 0);
      check("full_seq", seq, 32'hFFFFFFFF);
      search(4'hF, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0, lat, seq, fb);
      check("b2b_busy", fb, 1);
      check("b2b_lat", lat, 9);
      check("b2b_count", count, 8);
      tick;

      // Reset in cycle T+4 of a count-all scan
      start = 1'b1; key = 4'hF; mode = 1'b1;
      tick;
      start = 1'b0;
      tick; tick; tick;
      check("ar_busy_before", busy, 1);
      check("ar_count_before", count, 3);
      reset = 1'b0;
      #1;
      check("ar_busy", busy, 0);
      check("ar_done", done, 0);
      check("ar_found", found, 0);
      check("ar_index", index, 0);
      check("ar_count", count, 0);
      check("ar_io_out", io_out, 0);
      tick;
      reset = 1'b1;
      tick;
      search(4'd0, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0, lat, seq, fb);
      check("ar_zero_lat", lat, 9);
      check("ar_zero_count", count, 8);
      check("ar_zero_index", index, 0);
      check("ar_zero_found", found, 1);
      tick;
      search(4'hF, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, lat, seq, fb);
      check("ar_cleared_found", found, 0);
      check("ar_cleared_count", count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
